// File: rtl/de10nano_gpio_bank_if.sv
// de10nano_gpio_bank_if: MMIO bus between the core and the GPIO bank
interface de10nano_gpio_bank_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;
  modport master (output we, addr, wd, input rd, irq);
  modport slave  (input we, addr, wd, output rd, irq);
endinterface

// File: rtl/de10nano_gpio_bank.sv
// de10nano_gpio_bank: MMIO GPIO ports with direction, synchronised inputs, edge capture, W1C status and irq
module de10nano_gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int N_PORTS     = 2,
  parameter int PORT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  de10nano_gpio_bank_if.slave       bus,
  inout  wire  [N_PORTS*PORT_W-1:0] gpio
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM_END = CW'(SYNC_STAGES + 1);
  logic [PORT_W-1:0] r_out  [N_PORTS];
  logic [PORT_W-1:0] r_dir  [N_PORTS];
  logic [PORT_W-1:0] r_rise [N_PORTS];
  logic [PORT_W-1:0] r_fall [N_PORTS];
  logic [PORT_W-1:0] r_stat [N_PORTS];
  logic [PORT_W-1:0] r_ien  [N_PORTS];
  logic [PORT_W-1:0] r_prev [N_PORTS];
  logic [PORT_W-1:0] r_sync [N_PORTS][SYNC_STAGES];
  logic [CW-1:0]     r_warm;
  logic [WIDTH-1:0]  r_rd;
  logic              r_irq;
  logic [PORT_W-1:0] w_in   [N_PORTS];
  logic [PORT_W-1:0] w_edge [N_PORTS];
  logic [PORT_W-1:0] w_wd;
  logic [PORT_W-1:0] w_rdata;
  logic [2:0]        w_port;
  logic [2:0]        w_reg;
  logic              w_irq;
  logic              w_unused;
  assign w_port   = bus.addr[7:5];
  assign w_reg    = bus.addr[4:2];
  assign w_wd     = bus.wd[PORT_W-1:0];
  assign w_unused = ^{bus.addr[WIDTH-1:8], bus.addr[1:0], bus.wd};
  assign bus.rd   = r_rd;
  assign bus.irq  = r_irq;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    for (genvar b = 0; b < PORT_W; b++) begin : g_pin
      assign gpio[p*PORT_W + b] = r_dir[p][b] ? r_out[p][b] : 1'bz;
    end
  end
  // IN view (outputs read back OUT) and edge terms, gated until the synchroniser has settled
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_in[p]   = (r_dir[p] & r_out[p]) | (~r_dir[p] & r_sync[p][SYNC_STAGES-1]);
      w_edge[p] = (r_warm == WARM_END) ? ((w_in[p] & ~r_prev[p] & r_rise[p]) | (~w_in[p] & r_prev[p] & r_fall[p])) : '0;
    end
  end
  // read mux of pre-write state and the irq term; ports beyond N_PORTS read 0
  always_comb begin
    w_rdata = '0;
    w_irq   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_irq = w_irq | (|(r_stat[p] & r_ien[p]));
      if (w_port == 3'(p)) begin
        case (w_reg)
          3'd0:    w_rdata = r_out[p];
          3'd1:    w_rdata = r_dir[p];
          3'd2:    w_rdata = w_in[p];
          3'd4:    w_rdata = r_rise[p];
          3'd5:    w_rdata = r_fall[p];
          3'd6:    w_rdata = r_stat[p];
          3'd7:    w_rdata = r_ien[p];
          default: w_rdata = '0;
        endcase
      end
    end
  end
  // register file, synchroniser, edge status, warm-up counter, read data and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_PORTS; p++) begin
        r_out[p]  <= '0;
        r_dir[p]  <= '0;
        r_rise[p] <= '0;
        r_fall[p] <= '0;
        r_stat[p] <= '0;
        r_ien[p]  <= '0;
        r_prev[p] <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) r_sync[p][s] <= '0;
      end
      r_warm <= '0;
      r_rd   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_warm <= (r_warm == WARM_END) ? r_warm : r_warm + CW'(1);
      r_rd   <= WIDTH'(w_rdata);
      r_irq  <= w_irq;
      for (int p = 0; p < N_PORTS; p++) begin
        r_sync[p][0] <= gpio[p*PORT_W +: PORT_W];
        for (int s = 1; s < SYNC_STAGES; s++) r_sync[p][s] <= r_sync[p][s-1];
        r_prev[p] <= w_in[p];
        r_stat[p] <= (r_stat[p] & ~((bus.we && w_port == 3'(p) && w_reg == 3'd6) ? w_wd : '0)) | w_edge[p];
        if (bus.we && w_port == 3'(p)) begin
          case (w_reg)
            3'd0:    r_out[p]  <= w_wd;
            3'd1:    r_dir[p]  <= w_wd;
            3'd3:    r_out[p]  <= r_out[p] ^ w_wd;
            3'd4:    r_rise[p] <= w_wd;
            3'd5:    r_fall[p] <= w_wd;
            3'd7:    r_ien[p]  <= w_wd;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_de10nano_gpio_bank.sv
// tb_de10nano_gpio_bank: directed and randomized checks of the GPIO bank against a behavioural model
module tb_de10nano_gpio_bank;
  localparam int NP = 2;
  localparam int PW = 32;
  localparam int S  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  de10nano_gpio_bank_if #(.WIDTH(32)) bus ();
  wire  [NP*PW-1:0] gpio;
  logic [NP*PW-1:0] tb_pv;
  logic [NP*PW-1:0] tb_en;
  int total = 0;
  int bad = 0;
  logic [31:0] m_out [NP];
  logic [31:0] m_dir [NP];
  logic [31:0] m_rise [NP];
  logic [31:0] m_fall [NP];
  logic [31:0] m_stat [NP];
  logic [31:0] m_ien [NP];
  logic [31:0] m_prev [NP];
  logic [31:0] m_hist [NP][S];
  int          m_warm;
  logic [31:0] e_rd;
  logic        e_irq;

  de10nano_gpio_bank #(.WIDTH(32), .N_PORTS(NP), .PORT_W(PW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .bus(bus), .gpio(gpio)
  );

  for (genvar i = 0; i < NP*PW; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_pv[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_in(input int p);
    return (m_dir[p] & m_out[p]) | (~m_dir[p] & m_hist[p][S-1]);
  endfunction

  task automatic m_clear();
    for (int q = 0; q < NP; q++) begin
      m_out[q] = 0; m_dir[q] = 0; m_rise[q] = 0; m_fall[q] = 0;
      m_stat[q] = 0; m_ien[q] = 0; m_prev[q] = 0;
      for (int k = 0; k < S; k++) m_hist[q][k] = 0;
    end
    m_warm = 0;
  endtask

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    int p;
    int r;
    logic [31:0] inv;
    logic [31:0] edg;
    p = int'(a[7:5]);
    r = int'(a[4:2]);
    e_rd = 0;
    if (p < NP) begin
      case (r)
        0: e_rd = m_out[p];
        1: e_rd = m_dir[p];
        2: e_rd = m_in(p);
        4: e_rd = m_rise[p];
        5: e_rd = m_fall[p];
        6: e_rd = m_stat[p];
        7: e_rd = m_ien[p];
        default: e_rd = 0;
      endcase
    end
    e_irq = 1'b0;
    for (int q = 0; q < NP; q++) e_irq = e_irq | (|(m_stat[q] & m_ien[q]));
    for (int q = 0; q < NP; q++) begin
      inv = m_in(q);
      edg = (m_warm > S) ? ((inv & ~m_prev[q] & m_rise[q]) | (~inv & m_prev[q] & m_fall[q])) : 32'h0;
      if (w && p == q && r == 6) m_stat[q] = m_stat[q] & ~d;
      m_stat[q] = m_stat[q] | edg;
      m_prev[q] = inv;
      for (int k = S-1; k > 0; k--) m_hist[q][k] = m_hist[q][k-1];
      m_hist[q][0] = (m_dir[q] & m_out[q]) | (~m_dir[q] & tb_pv[q*PW +: PW]);
    end
    if (m_warm <= S) m_warm++;
    if (w && p < NP) begin
      case (r)
        0: m_out[p] = d;
        1: m_dir[p] = d;
        3: m_out[p] = m_out[p] ^ d;
        4: m_rise[p] = d;
        5: m_fall[p] = d;
        7: m_ien[p] = d;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.we = w; bus.addr = a; bus.wd = d;
    m_step(w, a, d);
    @(posedge clk); #1;
    chk($sformatf("rd@%h", a), bus.rd, e_rd);
    chk("irq", 32'(bus.irq), 32'(e_irq));
    bus.we = 1'b0;
    for (int q = 0; q < NP; q++) tb_en[q*PW +: PW] = ~m_dir[q];
    @(negedge clk);
    for (int q = 0; q < NP; q++) chk($sformatf("pad%0d", q), gpio[q*PW +: PW] & m_dir[q], m_out[q] & m_dir[q]);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic rdr(input logic [31:0] a);
    cyc(1'b0, a, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.we = 1'b0; bus.addr = 0; bus.wd = 0;
    @(posedge clk); #1;
    m_clear();
    chk("rst_rd", bus.rd, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    tb_en = '1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  pp;
    logic [2:0]  rr;
    bus.we = 1'b0; bus.addr = 0; bus.wd = 0;
    tb_pv = '1;
    tb_en = '1;
    m_clear();
    // reset with pads high, then read every register of both ports
    do_reset();
    for (int q = 0; q < NP; q++)
      for (int r = 0; r < 8; r++) rdr(32'(q*32 + r*4));
    rdr(32'h18);
    chk("rst_stat", bus.rd, 32'h0);
    // port0 low byte driven with 0xA5
    wr(32'h04, 32'h0000_00FF);
    wr(32'h00, 32'h0000_00A5);
    rdr(32'h08);
    rdr(32'h08);
    chk("in_a5", bus.rd, 32'hFFFF_FFA5);
    chk("pad_a5", 32'(gpio[7:0]), 32'hA5);
    // toggle on port1
    wr(32'h20, 32'h1);
    wr(32'h2C, 32'h3);
    rdr(32'h20);
    chk("toggle", bus.rd, 32'h2);
    rdr(32'h2C);
    chk("toggle_rd0", bus.rd, 32'h0);
    // rising edge on pin8, irq, then W1C
    tb_pv[8] = 1'b0;
    repeat (4) rdr(32'h18);
    wr(32'h10, 32'h100);
    wr(32'h1C, 32'h300);
    tb_pv[8] = 1'b1;
    repeat (S+2) rdr(32'h18);
    chk("stat_rise", bus.rd, 32'h100);
    chk("irq_rise", 32'(bus.irq), 32'h1);
    wr(32'h18, 32'h100);
    rdr(32'h18);
    chk("stat_w1c", bus.rd, 32'h0);
    chk("irq_clr", 32'(bus.irq), 32'h0);
    // falling edge on pin9 lands in the same cycle as its W1C
    wr(32'h14, 32'h200);
    tb_pv[9] = 1'b0;
    repeat (S) rdr(32'h18);
    wr(32'h18, 32'h200);
    rdr(32'h18);
    chk("set_wins", bus.rd, 32'h200);
    chk("irq_set_wins", 32'(bus.irq), 32'h1);
    wr(32'h14, 32'h0);
    rdr(32'h18);
    chk("fall_wr_keeps", bus.rd, 32'h200);
    wr(32'h18, 32'hFFFF_FFFF);
    // nonexistent port, and 0x20 aliasing port1 OUT
    wr(32'hA0, 32'hDEAD);
    rdr(32'hA0);
    chk("port5_rd", bus.rd, 32'h0);
    wr(32'h20, 32'h55);
    rdr(32'h20);
    chk("port1_out", bus.rd, 32'h55);
    rdr(32'h00);
    chk("port0_kept", bus.rd, 32'hA5);
    // warm-up: pads high through a restarted reset, rise enabled straight away
    tb_pv = '1;
    do_reset();
    rdr(32'h0);
    do_reset();
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h30, 32'hFFFF_FFFF);
    wr(32'h1C, 32'hFFFF_FFFF);
    repeat (S+3) rdr(32'h18);
    chk("warm_stat0", bus.rd, 32'h0);
    rdr(32'h38);
    chk("warm_stat1", bus.rd, 32'h0);
    chk("warm_irq", 32'(bus.irq), 32'h0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int q;
        q = $urandom_range(0, NP-1);
        tb_pv[q*PW +: PW] = tb_pv[q*PW +: PW] ^ ($urandom & $urandom & $urandom);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else begin
        pp = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, NP-1)) : 3'($urandom_range(0, 7));
        rr = 3'($urandom_range(0, 7));
        a  = {24'h0, pp, rr, 2'b00};
        d  = $urandom;
        if (rr == 3'd6) d = d & $urandom;
        cyc(1'($urandom_range(0, 1)), a, d);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
